// File: rtl/r_cpu_pkg.sv
// Shared R-type CPU constants: ALU operation codes (as produced by the
// decoder), R-type function codes, the R-type opcode and the instruction
// loader state type.
// Optional feature macro: R_LOADER_NOP_PAD_EN adds the PAD loader state.
package r_cpu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLLV = 4'b0111;

  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;
  localparam logic [5:0] FUNC_XOR  = 6'b100110;
  localparam logic [5:0] FUNC_NOR  = 6'b100111;
  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_SLT  = 6'b101010;
  localparam logic [5:0] FUNC_SLLV = 6'b000100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LOAD,
    LD_FLUSH,
`ifdef R_LOADER_NOP_PAD_EN
    LD_PAD,
`endif
    LD_DONE
  } loader_state_t;

endpackage

// File: rtl/r_encoder.sv
// Combinational R-type instruction encoder.
// Ports: alu_op/rs/rt/rd in; word = {OP_RTYPE, rs, rt, rd, shamt=0, func}
// out, op_valid low for the unused ALU codes 1000-1111 (word func is 0 then).
module r_encoder
  import r_cpu_pkg::*;
(
  input  logic [3:0]  alu_op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output logic [31:0] word,
  output logic        op_valid
);

  logic [5:0] func;

  always_comb begin
    func     = '0;
    op_valid = 1'b1;
    case (alu_op)
      ALU_AND:  func = FUNC_AND;
      ALU_OR:   func = FUNC_OR;
      ALU_XOR:  func = FUNC_XOR;
      ALU_NOR:  func = FUNC_NOR;
      ALU_ADD:  func = FUNC_ADD;
      ALU_SUB:  func = FUNC_SUB;
      ALU_SLT:  func = FUNC_SLT;
      ALU_SLLV: func = FUNC_SLLV;
      default:  op_valid = 1'b0;
    endcase
  end

  assign word = {OP_RTYPE, rs, rt, rd, 5'b00000, func};

endmodule

// File: rtl/r_inst_loader.sv
// Instruction-memory program loader for the R-type CPU.
// Accepts instruction requests over valid/ready, encodes them and writes
// them to consecutive instruction-memory addresses (registered write port,
// one cycle after acceptance). Holds the CPU in reset until the final write
// has committed.
// Ports: clk, reset (async, active-high), start; request in_valid/in_ready,
// in_alu_op, in_rs/in_rt/in_rd, in_last; memory mem_we/mem_addr/mem_wdata;
// status cpu_reset, done, err (sticky per load).
// Optional feature macro: R_LOADER_NOP_PAD_EN fills the unused tail of the
// memory with all-zero words before releasing the CPU.
module r_inst_loader
  import r_cpu_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_alu_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  loader_state_t     state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       enc_word;
  logic              enc_valid;
  logic              xfer;
`ifdef R_LOADER_NOP_PAD_EN
  // Set once DEPTH-1 has been written; lets FLUSH decide between PAD and
  // DONE even though the pointer has wrapped back to 0.
  logic              full;
`endif

  r_encoder u_encoder (
    .alu_op   (in_alu_op),
    .rs       (in_rs),
    .rt       (in_rt),
    .rd       (in_rd),
    .word     (enc_word),
    .op_valid (enc_valid)
  );

  assign in_ready  = (state == LD_LOAD);
  assign xfer      = in_valid && in_ready;
  assign cpu_reset = (state != LD_DONE);
  assign done      = (state == LD_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LD_IDLE;
      ptr       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
`ifdef R_LOADER_NOP_PAD_EN
      full      <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        LD_IDLE, LD_DONE: begin
          if (start) begin
            state <= LD_LOAD;
            ptr   <= '0;
            err   <= 1'b0;
`ifdef R_LOADER_NOP_PAD_EN
            full  <= 1'b0;
`endif
          end
        end
        LD_LOAD: begin
          if (xfer) begin
            if (enc_valid) begin
              mem_we    <= 1'b1;
              mem_addr  <= ptr;
              mem_wdata <= enc_word;
              ptr       <= ptr + ADDR_W'(1);
              // The top address always ends the program; without in_last
              // it is an overflow.
              if (ptr == LAST_ADDR) begin
                state <= LD_FLUSH;
                if (!in_last) err <= 1'b1;
`ifdef R_LOADER_NOP_PAD_EN
                full  <= 1'b1;
`endif
              end else if (in_last) begin
                state <= LD_FLUSH;
              end
            end else begin
              // Invalid op: accepted and flagged, but nothing written.
              err <= 1'b1;
              if (in_last) state <= LD_FLUSH;
            end
          end
        end
        LD_FLUSH: begin
`ifdef R_LOADER_NOP_PAD_EN
          // FLUSH is reused after PAD; full then routes it to DONE.
          state <= full ? LD_DONE : LD_PAD;
`else
          state <= LD_DONE;
`endif
        end
`ifdef R_LOADER_NOP_PAD_EN
        LD_PAD: begin
          mem_we    <= 1'b1;
          mem_addr  <= ptr;
          mem_wdata <= '0;
          ptr       <= ptr + ADDR_W'(1);
          if (ptr == LAST_ADDR) begin
            full  <= 1'b1;
            state <= LD_FLUSH;
          end
        end
`endif
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r_inst_loader.sv
module tb_r_inst_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared request fields and reset
  logic       rst;
  logic [3:0] op;
  logic [4:0] rs, rt, rd;
  logic       last;

  // DEPTH=64 instance
  logic        st0, v0, rdy0, we0, cr0, done0, err0;
  logic [5:0]  addr0;
  logic [31:0] wd0;
  // DEPTH=4 instance
  logic        st4, v4, rdy4, we4, cr4, done4, err4;
  logic [1:0]  addr4;
  logic [31:0] wd4;
  // DEPTH=8 instance
  logic        st8, v8, rdy8, we8, cr8, done8, err8;
  logic [2:0]  addr8;
  logic [31:0] wd8;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] W_ADD123 = 32'h0022_1820;
  localparam logic [31:0] W_SUB564 = 32'h00A6_2022;

  r_inst_loader #(.DEPTH(64), .ADDR_W(6)) u_d0 (
    .clk(clk), .reset(rst), .start(st0), .in_valid(v0), .in_ready(rdy0),
    .in_alu_op(op), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_last(last),
    .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
    .cpu_reset(cr0), .done(done0), .err(err0)
  );

  r_inst_loader #(.DEPTH(4), .ADDR_W(2)) u_d4 (
    .clk(clk), .reset(rst), .start(st4), .in_valid(v4), .in_ready(rdy4),
    .in_alu_op(op), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_last(last),
    .mem_we(we4), .mem_addr(addr4), .mem_wdata(wd4),
    .cpu_reset(cr4), .done(done4), .err(err4)
  );

  r_inst_loader #(.DEPTH(8), .ADDR_W(3)) u_d8 (
    .clk(clk), .reset(rst), .start(st8), .in_valid(v8), .in_ready(rdy8),
    .in_alu_op(op), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_last(last),
    .mem_we(we8), .mem_addr(addr8), .mem_wdata(wd8),
    .cpu_reset(cr8), .done(done8), .err(err8)
  );

  // Write logs, sampled away from the active edge
  logic [5:0]  q0a[$];
  logic [31:0] q0d[$];
  logic [2:0]  q8a[$];
  logic [31:0] q8d[$];

  always @(negedge clk) begin
    if (we0 === 1'b1) begin
      q0a.push_back(addr0);
      q0d.push_back(wd0);
    end
    if (we8 === 1'b1) begin
      q8a.push_back(addr8);
      q8d.push_back(wd8);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the DEPTH=64 loader to reach DONE (covers the padded build)
  task automatic settle0();
    int n;
    n = 0;
    while (done0 !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (done0 !== 1'b1) begin
      failures++;
      $display("FAIL settle0 done=%b required 1", done0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({we0, addr0, wd0, rdy0, cr0, done0, err0} !== {1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_d0 we=%b addr=%0d wdata=%h rdy=%b cpu_reset=%b done=%b err=%b required 0,0,0,0,1,0,0",
               we0, addr0, wd0, rdy0, cr0, done0, err0);
    end
    checks++;
    if ({rdy4, cr4, done4, rdy8, cr8, done8} !== 6'b010_010) begin
      failures++;
      $display("FAIL reset_d4_d8 got %b required 010010", {rdy4, cr4, done4, rdy8, cr8, done8});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (rdy0 !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready rdy=%b required 0", rdy0);
    end
  endtask

  task automatic test_single();
    q0a.delete();
    q0d.delete();
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    checks++;
    if ({rdy0, cr0, done0} !== 3'b110) begin
      failures++;
      $display("FAIL single_load_state rdy,cpu_reset,done=%b required 110", {rdy0, cr0, done0});
    end
    op = 4'b0100; rs = 5'd1; rt = 5'd2; rd = 5'd3; last = 1'b1; v0 = 1'b1;
    tick();
    v0 = 1'b0; last = 1'b0;
    checks++;
    if ({we0, addr0, wd0, rdy0, done0, cr0} !== {1'b1, 6'd0, W_ADD123, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL single_write we=%b addr=%0d wdata=%h rdy=%b done=%b cpu_reset=%b required 1,0,00221820,0,0,1",
               we0, addr0, wd0, rdy0, done0, cr0);
    end
    tick();
`ifndef R_LOADER_NOP_PAD_EN
    checks++;
    if ({we0, done0, cr0} !== 3'b010) begin
      failures++;
      $display("FAIL single_done we,done,cpu_reset=%b required 010", {we0, done0, cr0});
    end
`endif
    settle0();
    checks++;
    if (err0 !== 1'b0 || q0a.size() < 1 || q0a[0] !== 6'd0 || q0d[0] !== W_ADD123) begin
      failures++;
      $display("FAIL single_log err=%b writes=%0d required err 0 and first write 0:00221820", err0, q0a.size());
    end
  endtask

  task automatic test_back_to_back();
    q0a.delete();
    q0d.delete();
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    op = 4'b0100; rs = 5'd1; rt = 5'd2; rd = 5'd3; last = 1'b0; v0 = 1'b1;
    tick();
    checks++;
    if ({we0, addr0, wd0} !== {1'b1, 6'd0, W_ADD123}) begin
      failures++;
      $display("FAIL b2b_first we=%b addr=%0d wdata=%h required 1,0,00221820", we0, addr0, wd0);
    end
    op = 4'b0101; rs = 5'd5; rt = 5'd6; rd = 5'd4; last = 1'b1;
    tick();
    v0 = 1'b0; last = 1'b0;
    checks++;
    if ({we0, addr0, wd0} !== {1'b1, 6'd1, W_SUB564}) begin
      failures++;
      $display("FAIL b2b_second we=%b addr=%0d wdata=%h required 1,1,00a62022", we0, addr0, wd0);
    end
    tick();
`ifndef R_LOADER_NOP_PAD_EN
    checks++;
    if (done0 !== 1'b1 || q0a.size() != 2) begin
      failures++;
      $display("FAIL b2b_done done=%b writes=%0d required 1 and 2", done0, q0a.size());
    end
`endif
    settle0();
  endtask

  task automatic test_invalid_op();
    q0a.delete();
    q0d.delete();
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    op = 4'b0100; rs = 5'd1; rt = 5'd2; rd = 5'd3; last = 1'b0; v0 = 1'b1;
    tick();
    checks++;
    if ({we0, addr0, err0} !== {1'b1, 6'd0, 1'b0}) begin
      failures++;
      $display("FAIL inv_first we=%b addr=%0d err=%b required 1,0,0", we0, addr0, err0);
    end
    op = 4'b1010;
    tick();
    checks++;
    if ({we0, err0, rdy0} !== 3'b011) begin
      failures++;
      $display("FAIL inv_nowrite we,err,rdy=%b required 011", {we0, err0, rdy0});
    end
    op = 4'b0101; rs = 5'd5; rt = 5'd6; rd = 5'd4; last = 1'b1;
    tick();
    v0 = 1'b0; last = 1'b0;
    checks++;
    if ({we0, addr0, wd0, err0} !== {1'b1, 6'd1, W_SUB564, 1'b1}) begin
      failures++;
      $display("FAIL inv_next we=%b addr=%0d wdata=%h err=%b required 1,1,00a62022,1", we0, addr0, wd0, err0);
    end
    settle0();
    checks++;
    if (err0 !== 1'b1) begin
      failures++;
      $display("FAIL inv_sticky err=%b required 1", err0);
    end
  endtask

  task automatic test_mid_reset();
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    checks++;
    if ({err0, rdy0} !== 2'b01) begin
      failures++;
      $display("FAIL restart_clears_err err,rdy=%b required 01", {err0, rdy0});
    end
    op = 4'b0100; rs = 5'd1; rt = 5'd2; rd = 5'd3; last = 1'b0; v0 = 1'b1;
    tick();
    tick();
    v0 = 1'b0;
    checks++;
    if ({we0, addr0} !== {1'b1, 6'd1}) begin
      failures++;
      $display("FAIL mid_second we=%b addr=%0d required 1,1", we0, addr0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({we0, addr0, wd0, rdy0, cr0, done0, err0} !== {1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset we=%b addr=%0d wdata=%h rdy=%b cpu_reset=%b done=%b err=%b required 0,0,0,0,1,0,0",
               we0, addr0, wd0, rdy0, cr0, done0, err0);
    end
    tick();
    rst = 1'b0;
    tick();
    st0 = 1'b1;
    tick();
    st0 = 1'b0;
    op = 4'b0101; rs = 5'd5; rt = 5'd6; rd = 5'd4; last = 1'b1; v0 = 1'b1;
    tick();
    v0 = 1'b0; last = 1'b0;
    checks++;
    if ({we0, addr0, wd0} !== {1'b1, 6'd0, W_SUB564}) begin
      failures++;
      $display("FAIL reload_addr0 we=%b addr=%0d wdata=%h required 1,0,00a62022", we0, addr0, wd0);
    end
    settle0();
  endtask

  task automatic test_overflow();
    logic [31:0] exp4 [4];
    exp4[0] = 32'h0022_0020;
    exp4[1] = 32'h0022_0820;
    exp4[2] = 32'h0022_1020;
    exp4[3] = 32'h0022_1820;
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op = 4'b0100; rs = 5'd1; rt = 5'd2; rd = 5'(i); last = 1'b0; v4 = 1'b1;
      tick();
      checks++;
      if ({we4, addr4, wd4, err4} !== {1'b1, 2'(i), exp4[i], (i == 3)}) begin
        failures++;
        $display("FAIL ovf_write%0d we=%b addr=%0d wdata=%h err=%b required 1,%0d,%h,%0d",
                 i, we4, addr4, wd4, err4, i, exp4[i], (i == 3));
      end
    end
    checks++;
    if ({rdy4, done4} !== 2'b00) begin
      failures++;
      $display("FAIL ovf_flush rdy,done=%b required 00", {rdy4, done4});
    end
    tick();
    v4 = 1'b0;
    checks++;
    if ({we4, done4, cr4, err4, rdy4} !== 5'b01010) begin
      failures++;
      $display("FAIL ovf_done we,done,cpu_reset,err,rdy=%b required 01010", {we4, done4, cr4, err4, rdy4});
    end
  endtask

  task automatic test_pad();
    int n;
    q8a.delete();
    q8d.delete();
    st8 = 1'b1;
    tick();
    st8 = 1'b0;
    op = 4'b0100; rs = 5'd1; rt = 5'd2; rd = 5'd3; last = 1'b0; v8 = 1'b1;
    tick();
    op = 4'b0101; rs = 5'd5; rt = 5'd6; rd = 5'd4; last = 1'b1;
    tick();
    v8 = 1'b0; last = 1'b0;
    tick();
`ifdef R_LOADER_NOP_PAD_EN
    checks++;
    if (done8 !== 1'b0) begin
      failures++;
      $display("FAIL pad_not_done_early done=%b required 0", done8);
    end
    n = 0;
    while (done8 !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (done8 !== 1'b1 || q8a.size() != 8) begin
      failures++;
      $display("FAIL pad_done done=%b writes=%0d required 1 and 8", done8, q8a.size());
    end
    for (int j = 2; j < 8; j++) begin
      checks++;
      if (q8a.size() <= j || q8a[j] !== 3'(j) || q8d[j] !== 32'h0) begin
        failures++;
        $display("FAIL pad_word%0d writes=%0d required addr %0d data 00000000", j, q8a.size(), j);
      end
    end
`else
    n = 0;
    checks++;
    if ({done8, cr8, rdy8} !== 3'b100 || q8a.size() != 2) begin
      failures++;
      $display("FAIL nopad_done done,cpu_reset,rdy=%b writes=%0d required 100 and 2", {done8, cr8, rdy8}, q8a.size());
    end
`endif
    checks++;
    if (q8a.size() < 2 || q8a[0] !== 3'd0 || q8d[0] !== W_ADD123 || q8a[1] !== 3'd1 || q8d[1] !== W_SUB564) begin
      failures++;
      $display("FAIL pad_program writes=%0d required 0:00221820 1:00a62022 first", q8a.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    op = '0; rs = '0; rt = '0; rd = '0; last = 1'b0;
    st0 = 1'b0; v0 = 1'b0;
    st4 = 1'b0; v4 = 1'b0;
    st8 = 1'b0; v8 = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_invalid_op();
    test_mid_reset();
    test_overflow();
    test_pad();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
